// File: rtl/pes_bc_sched_if.sv
// Command/status bundle between the requesters, the scheduler and the count
// consumer. The optional wrap pulse exists only when PES_BC_SCHED_WRAP_EN is
// defined.
interface pes_bc_sched_if #(
  parameter int LEN_W = 4
);
  logic [1:0]         req;
  logic [1:0]         req_dir;
  logic [2*LEN_W-1:0] req_len;
  logic [1:0]         gnt;
  logic [3:0]         Count;
  logic               busy;
  logic               done;
  logic               done_id;
`ifdef PES_BC_SCHED_WRAP_EN
  logic               wrap;

  modport master (output req, req_dir, req_len,
                  input  gnt, Count, busy, done, done_id, wrap);
  modport slave  (input  req, req_dir, req_len,
                  output gnt, Count, busy, done, done_id, wrap);
`else
  modport master (output req, req_dir, req_len,
                  input  gnt, Count, busy, done, done_id);
  modport slave  (input  req, req_dir, req_len,
                  output gnt, Count, busy, done, done_id);
`endif
endinterface

// File: rtl/pes_bc_sched.sv
// Round-robin scheduler sharing one 4-bit up/down wrap-around counter between
// two requesters. A granted command steps the counter once per clock for the
// requested length, then pulses done. The counter value persists across runs.
// Optional feature macro: PES_BC_SCHED_WRAP_EN (adds the wrap pulse output).
module pes_bc_sched #(
  parameter int LEN_W = 4
) (
  input  logic Clk,
  input  logic reset,
  pes_bc_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic               winner;
  logic [LEN_W-1:0]   len_sel;
`ifdef PES_BC_SCHED_WRAP_EN
  logic               wrap_q, wrap_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef PES_BC_SCHED_WRAP_EN
    wrap_d    = 1'b0;
`endif
    // Only one requester high: it wins. Both high: the one that did not go last.
    winner  = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    len_sel = winner ? bus.req_len[2*LEN_W-1 -: LEN_W] : bus.req_len[LEN_W-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          owner_d       = winner;
          dir_d         = bus.req_dir[winner];
          rem_d         = len_sel;
          last_d        = winner;
          gnt_d[winner] = 1'b1;
          if (len_sel != '0) begin
            state_d = S_RUN;
          end else begin
            // Zero-length command completes without touching the counter.
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_id_d = winner;
          end
        end
      end
      S_RUN: begin
        count_d = dir_q ? count_q + 4'd1 : count_q - 4'd1;
`ifdef PES_BC_SCHED_WRAP_EN
        wrap_d  = dir_q ? (count_q == 4'hF) : (count_q == 4'h0);
`endif
        rem_d   = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
      end
      S_DONE: begin
        // Always return to IDLE; requests are not sampled on this edge.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any run in progress.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= 4'd0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef PES_BC_SCHED_WRAP_EN
      wrap_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef PES_BC_SCHED_WRAP_EN
      wrap_q    <= wrap_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.Count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
`ifdef PES_BC_SCHED_WRAP_EN
  assign bus.wrap    = wrap_q;
`endif

endmodule

// File: tb/tb_pes_bc_sched.sv
// Directed bench for pes_bc_sched: cycle tables for the single-run cases,
// hand-written sequences for round-robin alternation and mid-run reset.
module tb_pes_bc_sched;

  localparam int LEN_W = 4;

  typedef struct {
    logic [1:0] req;
    logic [1:0] dir;
    logic [7:0] len;
    logic [1:0] gnt;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       id;
    logic       wrap;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  pes_bc_sched_if #(.LEN_W(LEN_W)) bus();

  pes_bc_sched #(.LEN_W(LEN_W)) dut (
    .Clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [1:0] rq, logic [1:0] dr, logic [7:0] ln,
                               logic [1:0] g, logic [3:0] c, logic b, logic d,
                               logic id, logic w);
    vec_t v;
    v.req = rq; v.dir = dr; v.len = ln; v.gnt = g; v.cnt = c;
    v.busy = b; v.done = d; v.id = id; v.wrap = w;
    return v;
  endfunction

  // Apply each record before an edge, then compare outputs just after it.
  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.req     = vecs[i].req;
      bus.req_dir = vecs[i].dir;
      bus.req_len = vecs[i].len;
      tick();
      check($sformatf("%s[%0d].gnt", tag, i), 32'(bus.gnt), 32'(vecs[i].gnt));
      check($sformatf("%s[%0d].count", tag, i), 32'(bus.Count), 32'(vecs[i].cnt));
      check($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("%s[%0d].done", tag, i), 32'(bus.done), 32'(vecs[i].done));
      if (vecs[i].done)
        check($sformatf("%s[%0d].done_id", tag, i), 32'(bus.done_id), 32'(vecs[i].id));
`ifdef PES_BC_SCHED_WRAP_EN
      check($sformatf("%s[%0d].wrap", tag, i), 32'(bus.wrap), 32'(vecs[i].wrap));
`endif
    end
    vecs.delete();
    bus.req = 2'b00;
  endtask

  // Single command from requester r; waits (bounded) for done and checks the end count.
  task automatic run_cmd(input int r, input logic dir, input int len, input logic [3:0] exp_end);
    int n;
    bus.req        = 2'b00;
    bus.req[r]     = 1'b1;
    bus.req_dir    = {dir, dir};
    bus.req_len    = '0;
    bus.req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
    tick();
    check($sformatf("run%0d.gnt", r), 32'(bus.gnt), 32'(2'b01 << r));
    bus.req = 2'b00;
    n = 0;
    while (!bus.done && n < len + 2) begin
      tick();
      n++;
    end
    check("run.done", 32'(bus.done), 32'd1);
    check("run.steps", 32'(n), 32'(len));
    check("run.count", 32'(bus.Count), 32'(exp_end));
    check("run.done_id", 32'(bus.done_id), 32'(r));
    tick();
    check("run.idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.req     = 2'b00;
    bus.req_dir = 2'b00;
    bus.req_len = '0;
    tick();
    tick();
    check("rst.count", 32'(bus.Count), 32'd0);
    check("rst.gnt", 32'(bus.gnt), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.done_id", 32'(bus.done_id), 32'd0);
`ifdef PES_BC_SCHED_WRAP_EN
    check("rst.wrap", 32'(bus.wrap), 32'd0);
`endif
    rst = 1'b0;

    // req0 up len 3 from 0.
    vecs.push_back(mkv(2'b01, 2'b01, 8'h03, 2'b01, 4'd0, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd1, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd2, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd3, 1, 1, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd3, 0, 0, 0, 0));
    apply_vecs("up3");

    run_cmd(0, 1'b1, 11, 4'd14);

    // req1 up len 4 from 14: wraps 15 -> 0 on the second step.
    vecs.push_back(mkv(2'b10, 2'b10, 8'h40, 2'b10, 4'd14, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd15, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd0,  1, 0, 0, 1));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd1,  1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd2,  1, 1, 1, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd2,  0, 0, 0, 0));
    apply_vecs("upwrap");

    run_cmd(0, 1'b0, 1, 4'd1);

    // req0 down len 3 from 1: wraps 0 -> 15.
    vecs.push_back(mkv(2'b01, 2'b00, 8'h03, 2'b01, 4'd1,  1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd0,  1, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd15, 1, 0, 0, 1));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd14, 1, 1, 0, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd14, 0, 0, 0, 0));
    apply_vecs("dnwrap");

    // Maximum-length down run from 14 ends at 15.
    run_cmd(0, 1'b0, 15, 4'd15);

    // req1 len 0, held: grant and done together, regrant two cycles later.
    vecs.push_back(mkv(2'b10, 2'b00, 8'h00, 2'b10, 4'd15, 1, 1, 1, 0));
    vecs.push_back(mkv(2'b10, 2'b00, 8'h00, 2'b00, 4'd15, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 2'b00, 8'h00, 2'b10, 4'd15, 1, 1, 1, 0));
    vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 2'b00, 4'd15, 0, 0, 0, 0));
    apply_vecs("len0");

    // Both requesters held, len 2 up each: grants alternate 0,1,0,1 every 4 cycles.
    bus.req     = 2'b11;
    bus.req_dir = 2'b11;
    bus.req_len = 8'h22;
    for (int c = 0; c < 16; c++) begin
      logic id;
      id = logic'((c / 4) % 2);
      tick();
      check($sformatf("rr[%0d].gnt", c), 32'(bus.gnt),
            (c % 4 == 0) ? 32'(2'b01 << id) : 32'd0);
      check($sformatf("rr[%0d].done", c), 32'(bus.done), (c % 4 == 2) ? 32'd1 : 32'd0);
      if (c % 4 == 2)
        check($sformatf("rr[%0d].done_id", c), 32'(bus.done_id), 32'(id));
    end
    bus.req = 2'b00;
    check("rr.count", 32'(bus.Count), 32'd7);

    // Reset mid-run: req0 up len 10, reset after 4 steps, req held through reset.
    bus.req     = 2'b01;
    bus.req_dir = 2'b01;
    bus.req_len = 8'h0A;
    tick();
    check("mid.gnt", 32'(bus.gnt), 32'b01);
    for (int i = 0; i < 4; i++) tick();
    check("mid.count", 32'(bus.Count), 32'd11);
    rst = 1'b1;
    #1;
    check("mid.rst.count", 32'(bus.Count), 32'd0);
    check("mid.rst.busy", 32'(bus.busy), 32'd0);
    check("mid.rst.done", 32'(bus.done), 32'd0);
    tick();
    check("mid.rst.hold", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();
    check("mid.regnt", 32'(bus.gnt), 32'b01);
    check("mid.regnt.count", 32'(bus.Count), 32'd0);
    bus.req = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("mid.step[%0d].count", i), 32'(bus.Count), 32'(i));
      check($sformatf("mid.step[%0d].done", i), 32'(bus.done), (i == 10) ? 32'd1 : 32'd0);
    end
    check("mid.done_id", 32'(bus.done_id), 32'd0);
    tick();
    check("mid.idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
